// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Opcodes, flag bit positions and FSM states for alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int OPCODE_WIDTH = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ADD  = 4'd0,
    ADC  = 4'd1,
    SUB  = 4'd2,
    SBB  = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    LLOG = 4'd7,
    RLOG = 4'd8,
    LROT = 4'd9,
    RROT = 4'd10,
    RAR  = 4'd11,
    MUL  = 4'd12,
    MULH = 4'd13
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Unsigned shift-add multiplier, one partial product per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]    r_count;
  logic                    r_active;
  logic [DATA_WIDTH:0]     w_sum;

  // Add into the high half, then shift the whole accumulator right by one.
  assign w_sum = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
               + (r_b[0] ? {1'b0, r_a} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_a      <= a;
      r_b      <= b;
      r_acc    <= '0;
      r_count  <= '0;
      r_active <= 1'b1;
    end else if (r_active && (r_count != c_last)) begin
      r_acc   <= {w_sum, r_acc[DATA_WIDTH-1:1]};
      r_b     <= r_b >> 1;
      r_count <= r_count + 1'b1;
    end
  end

  assign done    = r_active && (r_count == c_last);
  assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Registered, handshaked integer ALU with NZCV flags and a
//               multi-cycle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]  data_in_a,
  input  logic [DATA_WIDTH-1:0]  data_in_b,
  input  logic [SHIFT_WIDTH-1:0] shift_amt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [3:0]             flags_out,
  output logic                   illegal_op
);

  state_e                  r_state;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [3:0]              r_flags;
  logic                    r_illegal;
  logic                    r_is_mulh;

  logic                    w_accept;
  logic                    w_out_free;
  logic                    w_is_mul;
  logic                    w_is_sub;
  logic                    w_cin;
  logic [DATA_WIDTH-1:0]   w_b_op;
  logic [DATA_WIDTH:0]     w_sum;
  logic                    w_arith_v;
  logic [DATA_WIDTH:0]     w_ll;
  logic [DATA_WIDTH:0]     w_rl;
  logic signed [DATA_WIDTH:0] w_ra;
  logic [DATA_WIDTH-1:0]   w_rotl;
  logic [DATA_WIDTH-1:0]   w_rotr;
  logic                    w_shift_nz;
  logic [DATA_WIDTH-1:0]   w_res;
  logic                    w_c;
  logic                    w_v;
  logic                    w_illegal;
  logic [3:0]              w_flags;

  logic                    w_mul_done;
  logic [2*DATA_WIDTH-1:0] w_product;
  logic [DATA_WIDTH-1:0]   w_mul_res;
  logic                    w_mul_cv;
  logic [3:0]              w_mul_flags;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = (opcode == MUL) || (opcode == MULH);
  assign w_is_sub   = (opcode == SUB) || (opcode == SBB);

  always_comb begin
    w_cin = 1'b0;
    case (opcode)
      ADC, SBB: w_cin = r_flags[FLAG_C];
      SUB:      w_cin = 1'b1;
      default:  w_cin = 1'b0;
    endcase
  end

  assign w_b_op    = w_is_sub ? ~data_in_b : data_in_b;
  assign w_sum     = {1'b0, data_in_a} + {1'b0, w_b_op} + {{DATA_WIDTH{1'b0}}, w_cin};
  assign w_arith_v = (data_in_a[DATA_WIDTH-1] == w_b_op[DATA_WIDTH-1])
                  && (w_sum[DATA_WIDTH-1] != data_in_a[DATA_WIDTH-1]);

  // The extra guard bit on each shifter catches the last bit shifted out.
  assign w_ll       = {1'b0, data_in_a} << shift_amt;
  assign w_rl       = {data_in_a, 1'b0} >> shift_amt;
  assign w_ra       = $signed({data_in_a, 1'b0}) >>> shift_amt;
  assign w_rotl     = (data_in_a << shift_amt) | (data_in_a >> (DATA_WIDTH - int'(shift_amt)));
  assign w_rotr     = (data_in_a >> shift_amt) | (data_in_a << (DATA_WIDTH - int'(shift_amt)));
  assign w_shift_nz = (shift_amt != '0);

  always_comb begin
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_illegal = 1'b0;
    case (opcode)
      ADD, ADC, SUB, SBB: begin
        w_res = w_sum[DATA_WIDTH-1:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = w_arith_v;
      end
      AND:  w_res = data_in_a & data_in_b;
      OR:   w_res = data_in_a | data_in_b;
      XOR:  w_res = data_in_a ^ data_in_b;
      LLOG: begin
        w_res = w_ll[DATA_WIDTH-1:0];
        w_c   = w_ll[DATA_WIDTH];
      end
      RLOG: begin
        w_res = w_rl[DATA_WIDTH:1];
        w_c   = w_rl[0];
      end
      RAR: begin
        w_res = w_ra[DATA_WIDTH:1];
        w_c   = w_ra[0];
      end
      LROT: begin
        w_res = w_rotl;
        w_c   = w_shift_nz && w_rotl[0];
      end
      RROT: begin
        w_res = w_rotr;
        w_c   = w_shift_nz && w_rotr[DATA_WIDTH-1];
      end
      MUL, MULH: w_res = '0;
      default:   w_illegal = 1'b1;
    endcase
  end

  assign w_flags = {w_res[DATA_WIDTH-1], (w_res == '0), w_c, w_v};

  seq_multiplier #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (w_accept && w_is_mul),
    .a       (data_in_a),
    .b       (data_in_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_mul_res   = r_is_mulh ? w_product[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : w_product[DATA_WIDTH-1:0];
  assign w_mul_cv    = !r_is_mulh && (w_product[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
  assign w_mul_flags = {w_mul_res[DATA_WIDTH-1], (w_mul_res == '0), w_mul_cv, w_mul_cv};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
      r_is_mulh   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state   <= MUL_BUSY;
              r_is_mulh <= (opcode == MULH);
            end else begin
              r_out_valid <= 1'b1;
              r_data      <= w_res;
              r_illegal   <= w_illegal;
              if (!w_illegal) r_flags <= w_flags;
            end
          end
        end
        MUL_BUSY: begin
          // Finished product waits here until the output register frees up.
          if (w_mul_done && w_out_free) begin
            r_out_valid <= 1'b1;
            r_data      <= w_mul_res;
            r_illegal   <= 1'b0;
            r_flags     <= w_mul_flags;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign data_out   = r_data;
  assign flags_out  = r_flags;
  assign illegal_op = r_illegal;

endmodule
`default_nettype wire
